// File: rtl/uart_rx_deser_if.sv
// Parallel word output of the UART receive engine toward the RX FIFO
// write port: the received word and its one-cycle write strobe.
interface uart_rx_deser_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;

    modport master (output o_data, output o_valid);
    modport slave  (input  o_data, input  o_valid);
endinterface

// File: rtl/uart_rx_deser.sv
// UART serial receive engine. Oversamples the line at 16x baud, rebuilds
// start/data/parity/stop framing and emits one parallel word per good frame.
// Parity and framing errors are reported through sticky flags.
module uart_rx_deser #(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_EN   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_baud_x16_tick,
    input  logic               i_parity_odd,
    input  logic               i_RX,
    input  logic               i_error_rst,
    output logic               o_busy,
    output logic [1:0]         o_rx_error,
    uart_rx_deser_if.master    rx_if
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_state;
    logic [3:0]             r_tick;
    logic [BW-1:0]          r_bit;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_valid;
    logic                   r_busy;
    logic [1:0]             r_err;
    logic                   r_par_odd;
    logic                   r_perr;

    logic                   w_rx_s;
    logic                   w_par_exp;

    // Oldest synchronizer flop is the only view of the line used for decisions.
    assign w_rx_s    = r_sync[SYNC_STAGES-1];
    // Expected parity bit: even parity is the XOR of the data, odd inverts it.
    assign w_par_exp = (^r_shift) ^ r_par_odd;

    assign rx_if.o_data  = r_data;
    assign rx_if.o_valid = r_valid;
    assign o_busy        = r_busy;
    assign o_rx_error    = r_err;

    // Metastability synchronizer for the asynchronous line, reset to idle-high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{1'b1}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_RX};
        end
    end

    // Frame state machine: tick/bit counting, shifting, delivery and error flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_tick    <= 4'd0;
            r_bit     <= {BW{1'b0}};
            r_shift   <= {DATA_WIDTH{1'b0}};
            r_data    <= {DATA_WIDTH{1'b0}};
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 2'b00;
            r_par_odd <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // Clear first; a set later in this block overrides the clear.
            if (i_error_rst) begin
                r_err <= 2'b00;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_tick  <= 4'd0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (i_baud_x16_tick) begin
                        if (r_tick == 4'd7) begin
                            r_tick <= 4'd0;
                            if (w_rx_s) begin
                                // Line went back high: a glitch, not a start bit.
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state   <= ST_DATA;
                                r_bit     <= {BW{1'b0}};
                                r_par_odd <= i_parity_odd;
                                r_perr    <= 1'b0;
                            end
                        end else begin
                            r_tick <= r_tick + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_baud_x16_tick) begin
                        if (r_tick == 4'd15) begin
                            r_tick  <= 4'd0;
                            r_shift <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
                            if (r_bit == BW'(DATA_WIDTH - 1)) begin
                                r_state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                            end else begin
                                r_bit <= r_bit + {{(BW-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            r_tick <= r_tick + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (i_baud_x16_tick) begin
                        if (r_tick == 4'd15) begin
                            r_tick  <= 4'd0;
                            r_perr  <= (w_rx_s != w_par_exp);
                            r_state <= ST_STOP;
                        end else begin
                            r_tick <= r_tick + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (i_baud_x16_tick) begin
                        if (r_tick == 4'd15) begin
                            r_tick <= 4'd0;
                            if (w_rx_s) begin
                                // Leave at mid stop bit so a back-to-back start is seen.
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                                if (r_perr) begin
                                    r_err[1] <= 1'b1;
                                end
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_err[0] <= 1'b1;
                                r_state  <= ST_WAIT_IDLE;
                            end
                        end else begin
                            r_tick <= r_tick + 4'd1;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    // Hold off while the line stays low so a break yields no frames.
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                        r_tick  <= 4'd0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tick  <= 4'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: one 8N1 instance and one 8-bit parity instance,
// each driven by a bit-level line model, with expected words and error flags
// derived from the frame that was sent.
module tb_uart_rx_deser;

    localparam int BIT_CLKS = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic parity_odd = 1'b0;
    logic error_rst = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic busy_a, busy_b;
    logic [1:0] err_a, err_b;
    int tick_cnt = 0;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic prev_va = 1'b0;
    logic prev_vb = 1'b0;
    logic dbl_valid = 1'b0;

    uart_rx_deser_if #(.DATA_WIDTH(8)) if_a ();
    uart_rx_deser_if #(.DATA_WIDTH(8)) if_b ();

    uart_rx_deser #(.DATA_WIDTH(8), .PARITY_EN(0), .SYNC_STAGES(2)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_baud_x16_tick(tick), .i_parity_odd(parity_odd),
        .i_RX(rx_a), .i_error_rst(error_rst), .o_busy(busy_a), .o_rx_error(err_a),
        .rx_if(if_a)
    );

    uart_rx_deser #(.DATA_WIDTH(8), .PARITY_EN(1), .SYNC_STAGES(2)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_baud_x16_tick(tick), .i_parity_odd(parity_odd),
        .i_RX(rx_b), .i_error_rst(error_rst), .o_busy(busy_b), .o_rx_error(err_b),
        .rx_if(if_b)
    );

    always #5 clk = ~clk;

    // x16 baud tick: one-cycle pulse every 16 clocks.
    always @(posedge clk) begin
        tick_cnt <= (tick_cnt == 15) ? 0 : tick_cnt + 1;
        tick     <= (tick_cnt == 15);
    end

    // Collect delivered words and flag any strobe lasting more than one cycle.
    always @(negedge clk) begin
        if (if_a.o_valid === 1'b1) q_a.push_back(if_a.o_data);
        if (if_b.o_valid === 1'b1) q_b.push_back(if_b.o_data);
        if ((if_a.o_valid && prev_va) || (if_b.o_valid && prev_vb)) dbl_valid <= 1'b1;
        prev_va <= if_a.o_valid;
        prev_vb <= if_b.o_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int line, input logic v, input int clks);
        if (line == 0) rx_a = v;
        else rx_b = v;
        repeat (clks) @(negedge clk);
    endtask

    // One frame: start, 8 data bits LSB first, optional parity, stop.
    task automatic send_frame(input int line, input logic [7:0] d, input bit with_par,
                              input logic pbit, input logic stop_bit);
        hold(line, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold(line, d[i], BIT_CLKS);
        if (with_par) hold(line, pbit, BIT_CLKS);
        hold(line, stop_bit, BIT_CLKS);
    endtask

    // Exactly one word expected since the queue was last emptied.
    task automatic expect_word(input string tag, input int line, input logic [7:0] exp);
        int sz;
        logic [7:0] got;
        sz = (line == 0) ? q_a.size() : q_b.size();
        chk({tag, "_cnt"}, sz, 1);
        if (sz > 0) begin
            got = (line == 0) ? q_a.pop_front() : q_b.pop_front();
            chk({tag, "_data"}, got, exp);
        end
        q_a.delete();
        q_b.delete();
    endtask

    task automatic pulse_error_rst();
        @(negedge clk) error_rst = 1'b1;
        @(negedge clk) error_rst = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] exp_err;
        logic pbit, podd, good_stop;
        int n0;

        repeat (5) @(negedge clk);
        chk("rst_valid_a", if_a.o_valid, 1'b0);
        chk("rst_data_a", if_a.o_data, 8'h00);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_err_a", err_a, 2'b00);
        chk("rst_valid_b", if_b.o_valid, 1'b0);
        chk("rst_err_b", err_b, 2'b00);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // 1: plain 8N1 frame
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        expect_word("t1", 0, 8'hA5);
        chk("t1_err", err_a, 2'b00);
        chk("t1_busy", busy_a, 1'b0);

        // 2: short glitch is a false start, then a real frame
        hold(0, 1'b0, 48);
        hold(0, 1'b1, 8 * 16 + 40);
        chk("t2_busy", busy_a, 1'b0);
        chk("t2_novalid", q_a.size(), 0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        expect_word("t2", 0, 8'h3C);

        // 3: odd parity, correct then wrong parity bit
        parity_odd = 1'b1;
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
        expect_word("t3a", 1, 8'h3C);
        chk("t3a_err", err_b, 2'b00);
        send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1);
        expect_word("t3b", 1, 8'h3C);
        chk("t3b_err", err_b, 2'b10);
        pulse_error_rst();
        chk("t3_clr", err_b, 2'b00);

        // 4: framing error with line held low (break)
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        hold(0, 1'b0, 2 * BIT_CLKS);
        chk("t4_novalid", q_a.size(), 0);
        chk("t4_err", err_a, 2'b01);
        chk("t4_busy_low", busy_a, 1'b1);
        hold(0, 1'b1, BIT_CLKS);
        chk("t4_busy_idle", busy_a, 1'b0);
        chk("t4_still_none", q_a.size(), 0);
        pulse_error_rst();
        chk("t4_clr", err_a, 2'b00);

        // 5: reset after four data bits of 0xF0
        d = 8'hF0;
        hold(0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) hold(0, d[i], BIT_CLKS);
        @(negedge clk);
        rx_a = 1'b1;
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("t5_busy", busy_a, 1'b0);
        chk("t5_valid", if_a.o_valid, 1'b0);
        chk("t5_data", if_a.o_data, 8'h00);
        chk("t5_err", err_a, 2'b00);
        hold(0, 1'b1, 5 * BIT_CLKS);
        chk("t5_novalid", q_a.size(), 0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        expect_word("t5", 0, 8'h81);

        // 6: back-to-back frames, no idle gap
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1);
        chk("t6_cnt", q_a.size(), 3);
        if (q_a.size() == 3) begin
            chk("t6_w0", q_a[0], 8'h00);
            chk("t6_w1", q_a[1], 8'hFF);
            chk("t6_w2", q_a[2], 8'h7E);
        end
        chk("t6_err", err_a, 2'b00);
        q_a.delete();
        hold(0, 1'b1, 64);

        // Random 8N1 frames, occasional bad stop bit
        exp_err = 2'b00;
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(0, 255));
            good_stop = ($urandom_range(0, 3) != 0);
            send_frame(0, d, 1'b0, 1'b0, good_stop);
            if (good_stop) begin
                expect_word("rnd_a", 0, d);
            end else begin
                exp_err[0] = 1'b1;
                hold(0, 1'b0, BIT_CLKS);
                hold(0, 1'b1, BIT_CLKS);
                n0 = q_a.size();
                chk("rnd_a_none", n0, 0);
            end
            chk("rnd_a_err", err_a, exp_err);
        end

        // Random parity frames: word always delivered, sticky parity flag
        exp_err = 2'b00;
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(0, 255));
            podd = 1'($urandom_range(0, 1));
            parity_odd = podd;
            pbit = 1'($urandom_range(0, 1));
            // Count ones in the word plus the parity bit: odd mode wants odd total.
            n0 = 0;
            for (int i = 0; i < 8; i++) n0 += d[i];
            n0 += pbit;
            if ((n0 % 2) != (podd ? 1 : 0)) exp_err[1] = 1'b1;
            send_frame(1, d, 1'b1, pbit, 1'b1);
            expect_word("rnd_b", 1, d);
            chk("rnd_b_err", err_b, exp_err);
        end

        chk("valid_width", dbl_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
